// File: rtl/bp_table.sv
// ============================================================================
// bp_table -- direction predictor and target generator for the fetch stage.
//
// Every entry of the table is a 2-bit saturating counter. The table is indexed
// by the word-aligned PC bits. In gshare mode (HIST_W > 0) those bits are
// XOR-ed with a speculative global history register. The design decodes the
// instruction being fetched and, in the same cycle, gives a redirect decision
// and the target address. The execute stage trains the table with the
// resolved outcome. A mispredict also rebuilds the speculative history from
// the snapshot that travelled with that branch.
//
// Parameters
//   ENTRIES   number of counters (power of two, 2..1024)
//   HIST_W    global history length; 0 = bimodal, 1..log2(ENTRIES) = gshare
//   CNT_INIT  reset value of every counter (2'b01 = weakly not-taken)
//
// Ports
//   clk               clock; all state changes on the rising edge
//   rst               asynchronous active-high reset
//   inst_i            fetched instruction
//   inst_addr_i       fetched instruction address
//   fetch_valid_i     inst_i is real and advances this cycle
//   isbranch_o        redirect fetch to branch_addr_o
//   branch_addr_o     predicted target (0 when not a JAL/B-type)
//   pred_hist_o       history used for this lookup (0 in bimodal mode)
//   upd_valid_i       a conditional branch resolved this cycle
//   upd_pc_i          address of the resolved branch
//   upd_hist_i        pred_hist_o captured when that branch was fetched
//   upd_taken_i       resolved direction
//   upd_mispredict_i  predicted direction differed from upd_taken_i
// ============================================================================
module bp_table #(
    parameter int         ENTRIES  = 64,
    parameter int         HIST_W   = 0,
    parameter logic [1:0] CNT_INIT = 2'b01,
    localparam int        IDX_W    = $clog2(ENTRIES),
    localparam int        HW       = (HIST_W > 0) ? HIST_W : 1
) (
    input  logic          clk,
    input  logic          rst,

    input  logic [31:0]   inst_i,
    input  logic [31:0]   inst_addr_i,
    input  logic          fetch_valid_i,
    output logic          isbranch_o,
    output logic [31:0]   branch_addr_o,
    output logic [HW-1:0] pred_hist_o,

    // Update channel: there is no ready signal. A beat is accepted on every
    // rising edge where upd_valid_i is high and rst is low, one branch per
    // cycle. upd_pc_i, upd_hist_i, upd_taken_i and upd_mispredict_i are
    // meaningful only while upd_valid_i is high.
    input  logic          upd_valid_i,
    input  logic [31:0]   upd_pc_i,
    input  logic [HW-1:0] upd_hist_i,
    input  logic          upd_taken_i,
    input  logic          upd_mispredict_i
);

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_btype;
    logic        is_jal;
    logic [31:0] b_imm;
    logic [31:0] j_imm;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];

    // funct3 010 and 011 are not conditional branches in the base ISA.
    assign is_btype = (opcode == OPC_BRANCH) &&
                      (funct3 != 3'b010) && (funct3 != 3'b011);
    assign is_jal   = (opcode == OPC_JAL);

    assign b_imm = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                    inst_i[30:25], inst_i[11:8], 1'b0};
    assign j_imm = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                    inst_i[20], inst_i[30:21], 1'b0};

    // ------------------------------------------------------------------
    // Global history (only real in gshare mode)
    // ------------------------------------------------------------------
    logic [HW-1:0] ghr;          // history value for the current lookup
    logic [HW-1:0] upd_hist_eff; // history term for the update index

    // ------------------------------------------------------------------
    // Counter table
    // ------------------------------------------------------------------
    logic [1:0]       cnt_q [ENTRIES];
    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [1:0]       lk_cnt;
    logic [1:0]       upd_cnt;
    logic [1:0]       upd_cnt_next;

    // History is zero-extended on the MSB side before the XOR.
    assign lk_idx  = inst_addr_i[IDX_W+1:2] ^ IDX_W'(ghr);
    assign upd_idx = upd_pc_i[IDX_W+1:2]    ^ IDX_W'(upd_hist_eff);

    assign lk_cnt  = cnt_q[lk_idx];
    assign upd_cnt = cnt_q[upd_idx];

    always_comb begin
        upd_cnt_next = upd_cnt;
        if (upd_taken_i) begin
            if (upd_cnt != 2'b11) upd_cnt_next = upd_cnt + 2'd1;
        end else begin
            if (upd_cnt != 2'b00) upd_cnt_next = upd_cnt - 2'd1;
        end
    end

    // The lookup reads the table combinationally. A same-cycle update to the
    // same entry therefore shows up only in the cycle after the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_INIT;
        end else if (upd_valid_i) begin
            cnt_q[upd_idx] <= upd_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Prediction outputs
    // ------------------------------------------------------------------
    always_comb begin
        isbranch_o    = 1'b0;
        branch_addr_o = 32'h0;
        if (is_jal) begin
            isbranch_o    = 1'b1;
            branch_addr_o = inst_addr_i + j_imm;
        end else if (is_btype) begin
            isbranch_o    = lk_cnt[1];
            branch_addr_o = inst_addr_i + b_imm;
        end
    end

    assign pred_hist_o = ghr;

    // ------------------------------------------------------------------
    // History register
    // ------------------------------------------------------------------
    generate
        if (HIST_W > 0) begin : g_ghr
            logic [HW-1:0] ghr_q;
            logic [HW-1:0] ghr_d;

            // A mispredict repair takes priority over the speculative shift
            // of a branch fetched in the same cycle. The repaired history is
            // the branch's own snapshot with its real outcome shifted in.
            // Truncating the concatenation to HW bits drops the oldest bit.
            // For HW == 1 that leaves just the new bit.
            always_comb begin
                ghr_d = ghr_q;
                if (upd_valid_i && upd_mispredict_i) begin
                    ghr_d = HW'({upd_hist_i, upd_taken_i});
                end else if (fetch_valid_i && is_btype) begin
                    ghr_d = HW'({ghr_q, isbranch_o});
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) ghr_q <= '0;
                else     ghr_q <= ghr_d;
            end

            assign ghr          = ghr_q;
            assign upd_hist_eff = upd_hist_i;
        end else begin : g_no_ghr
            // Bimodal: no history. The snapshot input is ignored and so is
            // the mispredict flag, which only repairs history.
            logic unused_hist;
            assign unused_hist  = ^{upd_hist_i, upd_mispredict_i, fetch_valid_i};
            assign ghr          = '0;
            assign upd_hist_eff = '0;
        end
    endgenerate

    // Only the index bits of the update PC select an entry.
    logic unused_upd_pc;
    assign unused_upd_pc = ^{upd_pc_i[31:IDX_W+2], upd_pc_i[1:0]};

endmodule

// File: tb/tb_bp_table.sv
// Bench for bp_table: a bimodal instance and a gshare instance share stimulus.
module tb_bp_table;

  logic        clk;
  logic        rst;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        fetch_valid;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [3:0]  upd_hist_g;
  logic [0:0]  upd_hist_b;
  logic        upd_taken;
  logic        upd_mispredict;

  logic        b_isb;
  logic [31:0] b_addr;
  logic [0:0]  b_hist;
  logic        g_isb;
  logic [31:0] g_addr;
  logic [3:0]  g_hist;

  int checks = 0;
  int errors = 0;

  // Scoreboards: bimodal {isbranch, target} and gshare {pred_hist, isbranch}.
  logic [32:0] exp_q[$];
  logic [4:0]  gexp_q[$];

  // The bimodal instance sees a history bit it is required to ignore.
  assign upd_hist_b = upd_hist_g[0];

  bp_table #(.ENTRIES(64), .HIST_W(0), .CNT_INIT(2'b01)) dut_bi (
    .clk(clk), .rst(rst),
    .inst_i(inst), .inst_addr_i(inst_addr), .fetch_valid_i(fetch_valid),
    .isbranch_o(b_isb), .branch_addr_o(b_addr), .pred_hist_o(b_hist),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_hist_i(upd_hist_b),
    .upd_taken_i(upd_taken), .upd_mispredict_i(upd_mispredict)
  );

  bp_table #(.ENTRIES(64), .HIST_W(4), .CNT_INIT(2'b01)) dut_gs (
    .clk(clk), .rst(rst),
    .inst_i(inst), .inst_addr_i(inst_addr), .fetch_valid_i(fetch_valid),
    .isbranch_o(g_isb), .branch_addr_o(g_addr), .pred_hist_o(g_hist),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_hist_i(upd_hist_g),
    .upd_taken_i(upd_taken), .upd_mispredict_i(upd_mispredict)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [31:0] mk_b(input logic [2:0] f3, input int off);
    logic [12:0] imm;
    imm = off[12:0];
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] mk_jal(input int off);
    logic [20:0] imm;
    imm = off[20:0];
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_fetch(input logic [31:0] i, input logic [31:0] a, input logic fv);
    inst        = i;
    inst_addr   = a;
    fetch_valid = fv;
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic [3:0] h,
                         input logic t, input logic m);
    upd_valid      = v;
    upd_pc         = pc;
    upd_hist_g     = h;
    upd_taken      = t;
    upd_mispredict = m;
  endtask

  task automatic exp_b(input logic isb, input logic [31:0] tgt);
    exp_q.push_back({isb, tgt});
  endtask

  task automatic exp_g(input logic [3:0] h, input logic isb);
    gexp_q.push_back({h, isb});
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic compare_now(input string tag);
    logic [32:0] e;
    logic [4:0]  g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_isb"}, 32'(b_isb), 32'(e[32]));
      chk({tag, "_tgt"}, b_addr, e[31:0]);
    end
    while (gexp_q.size() > 0) begin
      g = gexp_q.pop_front();
      chk({tag, "_ghist"}, 32'(g_hist), 32'(g[4:1]));
      chk({tag, "_gisb"}, 32'(g_isb), 32'(g[0]));
    end
  endtask

  task automatic sample(input string tag);
    @(negedge clk);
    compare_now(tag);
  endtask

  task automatic do_reset;
    next_cycle();
    rst = 1'b1;
    set_fetch(32'h13, 32'h0, 1'b0);
    set_upd(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    next_cycle();
    rst = 1'b0;
  endtask

  // Bimodal step: B-type (+16) lookup at addr, optional update.
  task automatic bstep(input string tag, input logic [31:0] addr, input logic uv,
                       input logic [31:0] upc, input logic ut, input logic e_isb);
    next_cycle();
    set_fetch(mk_b(3'b000, 16), addr, 1'b1);
    set_upd(uv, upc, 4'($urandom_range(0, 15)), ut, 1'b0);
    exp_b(e_isb, addr + 32'd16);
    sample(tag);
  endtask

  // Gshare step: arbitrary fetch plus update, check history and direction.
  task automatic gstep(input string tag, input logic [31:0] i, input logic [31:0] a,
                       input logic fv, input logic uv, input logic [31:0] upc,
                       input logic [3:0] uh, input logic ut, input logic um,
                       input logic [3:0] e_hist, input logic e_isb);
    next_cycle();
    set_fetch(i, a, fv);
    set_upd(uv, upc, uh, ut, um);
    exp_g(e_hist, e_isb);
    sample(tag);
  endtask

  // ---------------- decode vectors ----------------
  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        isb;
    logic [31:0] tgt;
  } vec_t;

  vec_t vecs[10];

  logic [31:0] beq16;
  logic [31:0] jal8;

  initial begin
    vecs[0] = '{mk_b(3'b000, 16),      32'h0000_0100, 1'b0, 32'h0000_0110};
    vecs[1] = '{mk_jal(-8),            32'h0000_0200, 1'b1, 32'h0000_01F8};
    vecs[2] = '{mk_b(3'b001, -4096),   32'h0000_0300, 1'b0, 32'hFFFF_F300};
    vecs[3] = '{mk_b(3'b111, 4094),    32'h0000_0040, 1'b0, 32'h0000_103E};
    vecs[4] = '{mk_b(3'b010, 16),      32'h0000_0100, 1'b0, 32'h0000_0000};
    vecs[5] = '{32'h0000_80E7,         32'h0000_0100, 1'b0, 32'h0000_0000};
    vecs[6] = '{mk_jal(32),            32'hFFFF_FFF0, 1'b1, 32'h0000_0010};
    vecs[7] = '{mk_jal(1048574),       32'h0000_1000, 1'b1, 32'h0010_0FFE};
    vecs[8] = '{32'h0000_0013,         32'h0000_0100, 1'b0, 32'h0000_0000};
    vecs[9] = '{mk_b(3'b100, -2),      32'h0000_0104, 1'b0, 32'h0000_0102};

    beq16 = mk_b(3'b000, 16);
    jal8  = mk_jal(-8);

    rst = 1'b1;
    set_fetch(32'h0, 32'h0, 1'b0);
    set_upd(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);

    // Reset state, before any clock edge.
    #3;
    exp_b(1'b0, 32'h0);
    exp_g(4'h0, 1'b0);
    compare_now("rst_state");
    chk("rst_bhist", 32'(b_hist), 32'h0);
    next_cycle();
    rst = 1'b0;

    // Decode table: counters at CNT_INIT, so B-types are not taken. History
    // must stay 0 (no taken B-type, and JAL never shifts).
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      set_fetch(vecs[i].inst, vecs[i].addr, 1'b1);
      exp_b(vecs[i].isb, vecs[i].tgt);
      exp_g(4'h0, vecs[i].isb);
      sample($sformatf("dec%0d", i));
    end

    // Bimodal training, separate entries, saturation at 0, aliasing.
    bstep("bi_t1",      32'h100, 1'b1, 32'h100, 1'b1, 1'b0);
    bstep("bi_t2",      32'h100, 1'b1, 32'h100, 1'b1, 1'b1);
    bstep("bi_hit",     32'h100, 1'b0, 32'h0,   1'b0, 1'b1);
    bstep("bi_sep",     32'h104, 1'b0, 32'h0,   1'b0, 1'b0);
    bstep("bi_nt1",     32'h100, 1'b1, 32'h100, 1'b0, 1'b1);
    bstep("bi_nt2",     32'h100, 1'b1, 32'h100, 1'b0, 1'b1);
    bstep("bi_nt3",     32'h100, 1'b1, 32'h100, 1'b0, 1'b0);
    bstep("bi_nt4",     32'h100, 1'b1, 32'h100, 1'b0, 1'b0);
    bstep("bi_t_low",   32'h100, 1'b1, 32'h100, 1'b1, 1'b0);
    bstep("bi_sat0",    32'h100, 1'b0, 32'h0,   1'b0, 1'b0);
    bstep("bi_alias_u", 32'h100, 1'b1, 32'h200, 1'b1, 1'b0);
    bstep("bi_alias_n", 32'h100, 1'b0, 32'h0,   1'b0, 1'b1);
    bstep("bi_alias_l", 32'h200, 1'b0, 32'h0,   1'b0, 1'b1);

    // Saturation at 3.
    do_reset();
    bstep("sat1",  32'h180, 1'b1, 32'h180, 1'b1, 1'b0);
    bstep("sat2",  32'h180, 1'b1, 32'h180, 1'b1, 1'b1);
    bstep("sat3",  32'h180, 1'b1, 32'h180, 1'b1, 1'b1);
    bstep("sat4",  32'h180, 1'b1, 32'h180, 1'b1, 1'b1);
    bstep("sat5",  32'h180, 1'b1, 32'h180, 1'b1, 1'b1);
    bstep("sat_nt1", 32'h180, 1'b1, 32'h180, 1'b0, 1'b1);
    bstep("sat_hold", 32'h180, 1'b0, 32'h0,  1'b0, 1'b1);
    bstep("sat_nt2", 32'h180, 1'b1, 32'h180, 1'b0, 1'b1);
    bstep("sat_low", 32'h180, 1'b0, 32'h0,   1'b0, 1'b0);

    // Gshare history behaviour.
    do_reset();
    gstep("gs_f1", beq16, 32'h100, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    gstep("gs_f2", beq16, 32'h104, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    gstep("gs_f3", beq16, 32'h108, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    gstep("gs_rep", beq16, 32'h10C, 1'b1, 1'b1, 32'h300, 4'b0101, 1'b1, 1'b1, 4'h0, 1'b0);
    gstep("gs_after_rep", beq16, 32'h100, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 4'b1011, 1'b0);
    gstep("gs_nofv", beq16, 32'h100, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 4'b1011, 1'b0);
    gstep("gs_spec", beq16, 32'h104, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 4'b1011, 1'b0);
    gstep("gs_jal", jal8, 32'h200, 1'b1, 1'b1, 32'h100, 4'b0110, 1'b1, 1'b0, 4'b0110, 1'b1);
    gstep("gs_tr", beq16, 32'h100, 1'b1, 1'b1, 32'h100, 4'b0110, 1'b1, 1'b0, 4'b0110, 1'b1);
    gstep("gs_shift1", 32'h13, 32'h100, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 4'b1101, 1'b0);

    // Asynchronous reset mid-stream.
    next_cycle();
    set_fetch(beq16, 32'h100, 1'b0);
    set_upd(1'b1, 32'h100, 4'h0, 1'b1, 1'b0);
    exp_b(1'b1, 32'h110);
    exp_g(4'b1101, 1'b0);
    sample("pre_rst1");
    next_cycle();
    exp_b(1'b1, 32'h110);
    exp_g(4'b1101, 1'b0);
    sample("pre_rst2");
    #2;
    rst = 1'b1;
    set_upd(1'b1, 32'h100, 4'b0101, 1'b1, 1'b1);
    #1;
    exp_b(1'b0, 32'h110);
    exp_g(4'h0, 1'b0);
    compare_now("async_rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_upd(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    exp_b(1'b0, 32'h110);
    exp_g(4'h0, 1'b0);
    sample("rst_upd_ignored");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
